// File: rtl/typing_race_scorer.sv
// Keystroke scoring engine for the typing race: buffers typed chars against
// the target word and tracks words, keystrokes, time, WPM and accuracy.
module typing_race_scorer #(
    parameter int MAX_LEN    = 25,
    parameter int CHAR_W     = 5,
    parameter int TIME_W     = 15,
    parameter int CNT_W      = 11,
    parameter int TICK_DIV   = 1000000,
    parameter int TIME_LIMIT = 18000,
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      mode,
    input  logic [TIME_W-1:0]         goal,
    input  logic                      ev_valid,
    input  logic [CHAR_W-1:0]         ev_code,
    input  logic [MAX_LEN*CHAR_W-1:0] word,
    input  logic [LW-1:0]             word_len,
    output logic                      word_adv,
    output logic [MAX_LEN*CHAR_W-1:0] typed,
    output logic [LW-1:0]             cursor,
    output logic [LW-1:0]             correct,
    output logic [TIME_W-1:0]         words_done,
    output logic [CNT_W-1:0]          total_keys,
    output logic [CNT_W-1:0]          total_correct,
    output logic [TIME_W-1:0]         elapsed,
    output logic [TIME_W-1:0]         remaining,
    output logic [9:0]                wpm,
    output logic [9:0]                acc,
    output logic                      busy,
    output logic                      finish
);

    localparam int DW  = $clog2(TICK_DIV);
    localparam int NW  = (CNT_W + 12 > TIME_W) ? CNT_W + 12 : TIME_W;
    localparam int AW  = CNT_W + 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic [TIME_W-1:0]         goal_q, goal_d;
    logic [MAX_LEN*CHAR_W-1:0] typed_q, typed_d;
    logic [LW-1:0]             cursor_q, cursor_d;
    logic [LW-1:0]             correct_q, correct_d;
    logic [TIME_W-1:0]         words_q, words_d;
    logic [TIME_W-1:0]         elapsed_q, elapsed_d;
    logic [CNT_W-1:0]          keys_q, keys_d;
    logic [CNT_W-1:0]          tc_q, tc_d;
    logic [DW-1:0]             div_q, div_d;
    logic                      adv_q, adv_d;
    logic [9:0]                wpm_q, wpm_d;
    logic [9:0]                acc_q, acc_d;

    logic              run, fin_c;
    logic              is_letter, is_back, is_space;
    logic [LW-1:0]     cur_idx, bk_idx;
    logic [CHAR_W-1:0] tgt_c;
    logic              bonus;
    logic [CNT_W:0]    keys_inc, tc_sum, score;
    logic [TIME_W:0]   words_inc;
    logic [CNT_W-1:0]  keys_sat, tc_sat;
    logic [TIME_W-1:0] words_sat;
    logic [NW-1:0]     wpm_num, wpm_quo;
    logic [AW-1:0]     acc_num, acc_quo;

    assign run       = (state_q == S_RUN);
    assign fin_c     = (elapsed_q == TIME_W'(TIME_LIMIT))
                     || (!mode_q && elapsed_q >= goal_q)
                     || (mode_q && words_q >= goal_q);

    assign is_letter = (ev_code != '0) && (ev_code <= CHAR_W'(26));
    assign is_back   = (ev_code == CHAR_W'(27));
    assign is_space  = (ev_code == CHAR_W'(28));

    // Clamp so the part-select stays in range when the buffer is full.
    assign cur_idx   = (cursor_q < LW'(MAX_LEN)) ? cursor_q : '0;
    assign bk_idx    = cursor_q - LW'(1);
    assign tgt_c     = word[cur_idx*CHAR_W +: CHAR_W];
    assign bonus     = (correct_q == word_len) && (cursor_q == word_len);

    assign keys_inc  = {1'b0, keys_q} + (CNT_W+1)'(1);
    assign keys_sat  = keys_inc[CNT_W] ? '1 : keys_inc[CNT_W-1:0];
    assign tc_sum    = {1'b0, tc_q} + (CNT_W+1)'(correct_q)
                     + (CNT_W+1)'(bonus);
    assign tc_sat    = tc_sum[CNT_W] ? '1 : tc_sum[CNT_W-1:0];
    assign words_inc = {1'b0, words_q} + (TIME_W+1)'(1);
    assign words_sat = words_inc[TIME_W] ? '1 : words_inc[TIME_W-1:0];

    // The word in progress counts toward the live score.
    assign score     = {1'b0, tc_q} + (CNT_W+1)'(correct_q);
    assign wpm_num   = NW'(score) * NW'(1200);
    assign wpm_quo   = (elapsed_q == '0) ? '0 : wpm_num / NW'(elapsed_q);
    assign acc_num   = AW'(score) * AW'(100);
    assign acc_quo   = (keys_q == '0) ? '0 : acc_num / AW'(keys_q);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        goal_d    = goal_q;
        typed_d   = typed_q;
        cursor_d  = cursor_q;
        correct_d = correct_q;
        words_d   = words_q;
        elapsed_d = elapsed_q;
        keys_d    = keys_q;
        tc_d      = tc_q;
        div_d     = div_q;
        adv_d     = 1'b0;
        wpm_d     = wpm_q;
        acc_d     = acc_q;

        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (fin_c) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase

        if (run) begin
            wpm_d = (wpm_quo > NW'(1023)) ? 10'd1023 : wpm_quo[9:0];
            acc_d = (acc_quo > AW'(100)) ? 10'd100 : acc_quo[9:0];

            if (div_q == DW'(TICK_DIV - 1)) begin
                div_d = '0;
                if (elapsed_q != TIME_W'(TIME_LIMIT))
                    elapsed_d = elapsed_q + TIME_W'(1);
            end else begin
                div_d = div_q + DW'(1);
            end

            if (ev_valid) begin
                unique case (1'b1)
                    is_letter: begin
                        if (cursor_q < LW'(MAX_LEN)) begin
                            typed_d[cur_idx*CHAR_W +: CHAR_W] = ev_code;
                            cursor_d = cursor_q + LW'(1);
                            keys_d   = keys_sat;
                            if (cursor_q == correct_q
                                && cursor_q < word_len
                                && ev_code == tgt_c)
                                correct_d = correct_q + LW'(1);
                        end
                    end
                    is_back: begin
                        if (cursor_q != '0) begin
                            typed_d[bk_idx*CHAR_W +: CHAR_W] = '0;
                            cursor_d = bk_idx;
                            if (correct_q == cursor_q)
                                correct_d = correct_q - LW'(1);
                        end
                    end
                    is_space: begin
                        if (cursor_q != '0) begin
                            keys_d    = keys_sat;
                            words_d   = words_sat;
                            tc_d      = tc_sat;
                            adv_d     = 1'b1;
                            typed_d   = '0;
                            cursor_d  = '0;
                            correct_d = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (start) begin
            state_d   = S_RUN;
            mode_d    = mode;
            goal_d    = goal;
            typed_d   = '0;
            cursor_d  = '0;
            correct_d = '0;
            words_d   = '0;
            elapsed_d = '0;
            keys_d    = '0;
            tc_d      = '0;
            div_d     = '0;
            adv_d     = 1'b0;
            wpm_d     = '0;
            acc_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            goal_q    <= '0;
            typed_q   <= '0;
            cursor_q  <= '0;
            correct_q <= '0;
            words_q   <= '0;
            elapsed_q <= '0;
            keys_q    <= '0;
            tc_q      <= '0;
            div_q     <= '0;
            adv_q     <= 1'b0;
            wpm_q     <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            goal_q    <= goal_d;
            typed_q   <= typed_d;
            cursor_q  <= cursor_d;
            correct_q <= correct_d;
            words_q   <= words_d;
            elapsed_q <= elapsed_d;
            keys_q    <= keys_d;
            tc_q      <= tc_d;
            div_q     <= div_d;
            adv_q     <= adv_d;
            wpm_q     <= wpm_d;
            acc_q     <= acc_d;
        end
    end

    assign remaining     = mode_q
        ? ((words_q >= goal_q) ? '0 : goal_q - words_q)
        : ((elapsed_q >= goal_q) ? '0 : goal_q - elapsed_q);

    assign word_adv      = adv_q;
    assign typed         = typed_q;
    assign cursor        = cursor_q;
    assign correct       = correct_q;
    assign words_done    = words_q;
    assign total_keys    = keys_q;
    assign total_correct = tc_q;
    assign elapsed       = elapsed_q;
    assign wpm           = wpm_q;
    assign acc           = acc_q;
    assign busy          = (state_q == S_RUN);
    assign finish        = (state_q == S_DONE);

endmodule

// File: tb/tb_typing_race_scorer.sv
// Directed bench for typing_race_scorer with a short buffer and fast tick.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_typing_race_scorer;

    localparam int ML = 4;
    localparam int CW = 5;
    localparam int TW = 15;
    localparam int NC = 11;
    localparam int LW = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [TW-1:0]    goal = '0;
    logic             ev_valid = 1'b0;
    logic [CW-1:0]    ev_code = '0;
    logic [ML*CW-1:0] word = {5'd0, 5'd20, 5'd1, 5'd3};
    logic [LW-1:0]    word_len = 3'd3;
    logic             word_adv;
    logic [ML*CW-1:0] typed;
    logic [LW-1:0]    cursor, correct;
    logic [TW-1:0]    words_done, elapsed, remaining;
    logic [NC-1:0]    total_keys, total_correct;
    logic [9:0]       wpm, acc;
    logic             busy, finish;

    int total = 0;
    int bad = 0;
    int adv_cnt = 0;

    typing_race_scorer #(
        .MAX_LEN(ML), .CHAR_W(CW), .TIME_W(TW), .CNT_W(NC),
        .TICK_DIV(4), .TIME_LIMIT(100)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .goal(goal),
        .ev_valid(ev_valid), .ev_code(ev_code), .word(word),
        .word_len(word_len), .word_adv(word_adv), .typed(typed),
        .cursor(cursor), .correct(correct), .words_done(words_done),
        .total_keys(total_keys), .total_correct(total_correct),
        .elapsed(elapsed), .remaining(remaining), .wpm(wpm), .acc(acc),
        .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (word_adv === 1'b1) adv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic key(input logic [CW-1:0] c);
        ev_code  = c;
        ev_valid = 1'b1;
        @(negedge clk);
        ev_valid = 1'b0;
        ev_code  = '0;
    endtask

    task automatic go(input logic m, input logic [TW-1:0] g);
        mode  = m;
        goal  = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        total++; if (finish !== 1'b0) begin bad++; $display("FAIL rst_finish got=%0d exp=0", finish); end
        total++; if (cursor !== 3'd0) begin bad++; $display("FAIL rst_cursor got=%0d exp=0", cursor); end
        total++; if (elapsed !== 15'd0) begin bad++; $display("FAIL rst_elapsed got=%0d exp=0", elapsed); end
        total++; if (wpm !== 10'd0 || acc !== 10'd0) begin bad++; $display("FAIL rst_wpm_acc got=%0d/%0d exp=0/0", wpm, acc); end
        total++; if (remaining !== 15'd0) begin bad++; $display("FAIL rst_remaining got=%0d exp=0", remaining); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int a0;
        go(1'b1, 15'd100);
        key(5'd3);
        total++; if (correct !== 3'd1) begin bad++; $display("FAIL t2_c got=%0d exp=1", correct); end
        total++; if (typed !== 20'd3) begin bad++; $display("FAIL t2_typed got=%0h exp=3", typed); end
        key(5'd1);
        total++; if (correct !== 3'd2) begin bad++; $display("FAIL t2_a got=%0d exp=2", correct); end
        key(5'd20);
        total++; if (correct !== 3'd3) begin bad++; $display("FAIL t2_t got=%0d exp=3", correct); end
        a0 = adv_cnt;
        key(5'd28);
        total++; if (word_adv !== 1'b1) begin bad++; $display("FAIL t2_adv got=%0d exp=1", word_adv); end
        total++; if (correct !== 3'd0 || cursor !== 3'd0) begin bad++; $display("FAIL t2_clear got=%0d/%0d exp=0/0", correct, cursor); end
        total++; if (total_keys !== 11'd4) begin bad++; $display("FAIL t2_keys got=%0d exp=4", total_keys); end
        total++; if (total_correct !== 11'd4) begin bad++; $display("FAIL t2_tc got=%0d exp=4", total_correct); end
        total++; if (words_done !== 15'd1) begin bad++; $display("FAIL t2_words got=%0d exp=1", words_done); end
        @(negedge clk);
        total++; if (adv_cnt !== a0 + 1 || word_adv !== 1'b0) begin bad++; $display("FAIL t2_pulse got=%0d exp=%0d", adv_cnt - a0, 1); end
    endtask

    task automatic test_backspace();
        go(1'b1, 15'd100);
        key(5'd3);
        key(5'd24);
        total++; if (correct !== 3'd1 || cursor !== 3'd2) begin bad++; $display("FAIL t3_x got=%0d/%0d exp=1/2", correct, cursor); end
        total++; if (typed !== {10'd0, 5'd24, 5'd3}) begin bad++; $display("FAIL t3_typed got=%0h exp=303", typed); end
        key(5'd27);
        total++; if (correct !== 3'd1 || typed !== 20'd3) begin bad++; $display("FAIL t3_back got=%0d/%0h exp=1/3", correct, typed); end
        key(5'd1);
        key(5'd20);
        total++; if (correct !== 3'd3) begin bad++; $display("FAIL t3_t got=%0d exp=3", correct); end
        key(5'd28);
        total++; if (total_keys !== 11'd5) begin bad++; $display("FAIL t3_keys got=%0d exp=5", total_keys); end
        total++; if (total_correct !== 11'd4) begin bad++; $display("FAIL t3_tc got=%0d exp=4", total_correct); end
        repeat (2) @(negedge clk);
        total++; if (acc !== 10'd80) begin bad++; $display("FAIL t3_acc got=%0d exp=80", acc); end
        total++; if (wpm !== 10'd1023) begin bad++; $display("FAIL t3_wpm_sat got=%0d exp=1023", wpm); end
    endtask

    task automatic test_overflow();
        int a0;
        go(1'b1, 15'd100);
        repeat (5) key(5'd1);
        total++; if (cursor !== 3'd4) begin bad++; $display("FAIL t4_cursor got=%0d exp=4", cursor); end
        total++; if (total_keys !== 11'd4) begin bad++; $display("FAIL t4_keys got=%0d exp=4", total_keys); end
        total++; if (typed !== {4{5'd1}}) begin bad++; $display("FAIL t4_typed got=%0h exp=8421", typed); end
        total++; if (correct !== 3'd0) begin bad++; $display("FAIL t4_correct got=%0d exp=0", correct); end
        go(1'b1, 15'd100);
        a0 = adv_cnt;
        key(5'd28);
        key(5'd27);
        @(negedge clk);
        total++; if (adv_cnt !== a0) begin bad++; $display("FAIL t4_noadv got=%0d exp=%0d", adv_cnt, a0); end
        total++; if (total_keys !== 11'd0 || words_done !== 15'd0 || cursor !== 3'd0) begin bad++; $display("FAIL t4_empty got=%0d/%0d/%0d exp=0/0/0", total_keys, words_done, cursor); end
    endtask

    task automatic test_timeout();
        go(1'b0, 15'd10);
        total++; if (elapsed !== 15'd0 || remaining !== 15'd10) begin bad++; $display("FAIL t5_start got=%0d/%0d exp=0/10", elapsed, remaining); end
        repeat (39) @(negedge clk);
        total++; if (elapsed !== 15'd9 || remaining !== 15'd1) begin bad++; $display("FAIL t5_39 got=%0d/%0d exp=9/1", elapsed, remaining); end
        @(negedge clk);
        total++; if (elapsed !== 15'd10 || finish !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL t5_40 got=%0d/%0d/%0d exp=10/0/1", elapsed, finish, busy); end
        @(negedge clk);
        total++; if (finish !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL t5_done got=%0d/%0d exp=1/0", finish, busy); end
        key(5'd1);
        total++; if (cursor !== 3'd0 || total_keys !== 11'd0) begin bad++; $display("FAIL t5_drop got=%0d/%0d exp=0/0", cursor, total_keys); end
        total++; if (finish !== 1'b1) begin bad++; $display("FAIL t5_sticky got=%0d exp=1", finish); end
    endtask

    task automatic test_words();
        int n;
        go(1'b1, 15'd2);
        key(5'd3); key(5'd1); key(5'd20); key(5'd28);
        key(5'd3); key(5'd1); key(5'd20);
        n = 0;
        while (elapsed !== 15'd60 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++; if (elapsed !== 15'd60) begin bad++; $display("FAIL t6_wait got=%0d exp=60", elapsed); end
        key(5'd28);
        @(negedge clk);
        total++; if (finish !== 1'b1) begin bad++; $display("FAIL t6_finish got=%0d exp=1", finish); end
        total++; if (total_correct !== 11'd8 || words_done !== 15'd2) begin bad++; $display("FAIL t6_tot got=%0d/%0d exp=8/2", total_correct, words_done); end
        total++; if (wpm !== 10'd160) begin bad++; $display("FAIL t6_wpm got=%0d exp=160", wpm); end
        total++; if (acc !== 10'd100) begin bad++; $display("FAIL t6_acc got=%0d exp=100", acc); end
        total++; if (remaining !== 15'd0) begin bad++; $display("FAIL t6_rem got=%0d exp=0", remaining); end
        repeat (3) @(negedge clk);
        total++; if (wpm !== 10'd160 || acc !== 10'd100) begin bad++; $display("FAIL t6_hold got=%0d/%0d exp=160/100", wpm, acc); end
        go(1'b1, 15'd5);
        total++; if (busy !== 1'b1 || finish !== 1'b0) begin bad++; $display("FAIL t6_rs_state got=%0d/%0d exp=1/0", busy, finish); end
        total++; if (total_keys !== 11'd0 || total_correct !== 11'd0 || words_done !== 15'd0) begin bad++; $display("FAIL t6_rs_cnt got=%0d/%0d/%0d exp=0/0/0", total_keys, total_correct, words_done); end
        total++; if (elapsed !== 15'd0 || wpm !== 10'd0 || acc !== 10'd0) begin bad++; $display("FAIL t6_rs_stat got=%0d/%0d/%0d exp=0/0/0", elapsed, wpm, acc); end
        total++; if (remaining !== 15'd5) begin bad++; $display("FAIL t6_rs_rem got=%0d exp=5", remaining); end
    endtask

    task automatic test_midrun_reset();
        go(1'b1, 15'd100);
        key(5'd3);
        key(5'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        total++; if (cursor !== 3'd0 || typed !== 20'd0 || total_keys !== 11'd0) begin bad++; $display("FAIL t1_clr got=%0d/%0h/%0d exp=0/0/0", cursor, typed, total_keys); end
        total++; if (busy !== 1'b0 || finish !== 1'b0 || word_adv !== 1'b0) begin bad++; $display("FAIL t1_flags got=%0d/%0d/%0d exp=0/0/0", busy, finish, word_adv); end
        total++; if (wpm !== 10'd0 || acc !== 10'd0 || remaining !== 15'd0) begin bad++; $display("FAIL t1_stat got=%0d/%0d/%0d exp=0/0/0", wpm, acc, remaining); end
        key(5'd1);
        @(negedge clk);
        total++; if (cursor !== 3'd0 || total_keys !== 11'd0 || busy !== 1'b0) begin bad++; $display("FAIL t1_idle got=%0d/%0d/%0d exp=0/0/0", cursor, total_keys, busy); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backspace();
        test_overflow();
        test_timeout();
        test_words();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
